// File: rtl/fifo_reader.sv
// fifo_reader: drains a registered-flag FIFO into a 4-entry skid buffer.
// Pops are credit-limited so words already requested always have a slot.
module fifo_reader #(
    parameter int data_width = 10,
    parameter int RD_LAT = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_fifo,
    input  logic                  almost_empty_fifo,
    input  logic [data_width-1:0] FIFO_data_out,
    output logic                  pop,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [15:0]           word_cnt,
    output logic                  error
);
    localparam int WW = $clog2(RD_LAT + 1);
    typedef enum logic [1:0] {IDLE, BURST, SINGLE, WAIT} state_t;
    state_t state, state_nxt;
    logic pop_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [RD_LAT-1:0] inflight;
    logic [data_width-1:0] mem [4];
    logic [1:0] wp, rp;
    logic [2:0] occ;
    logic [3:0] infl_cnt, credit;
    logic wr, wr_ok, rd, have;
    assign wr = inflight[RD_LAT-1];
    assign wr_ok = wr && occ != 3'd4;
    assign valid_out = occ != 3'd0;
    assign rd = valid_out && ready_in;
    assign data_out = mem[rp];
    always_comb begin
        infl_cnt = 4'(pop);
        for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + 4'(inflight[i]);
    end
    // Credit as seen by the next pop; a word leaving this cycle frees its slot in time.
    assign credit = 4'(BUF_DEPTH) + 4'(rd) - 4'(occ) - infl_cnt;
    assign have = credit != 4'd0;
    always_comb begin
        state_nxt = state;
        pop_nxt = 1'b0;
        wait_nxt = '0;
        case (state)
            IDLE: if (!empty_fifo && have) begin
                state_nxt = almost_empty_fifo ? SINGLE : BURST;
                pop_nxt = 1'b1;
            end
            BURST: if (empty_fifo || almost_empty_fifo) state_nxt = WAIT;
                   else pop_nxt = have;
            SINGLE: state_nxt = WAIT;
            WAIT: begin
                wait_nxt = wait_cnt + WW'(1);
                if (wait_cnt == WW'(RD_LAT - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            pop <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            pop <= pop_nxt;
            wait_cnt <= wait_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight <= '0;
            wp <= 2'd0;
            rp <= 2'd0;
            occ <= 3'd0;
            word_cnt <= 16'd0;
            error <= 1'b0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            inflight <= RD_LAT'({inflight, pop});
            if (wr_ok) begin
                mem[wp] <= FIFO_data_out;
                wp <= wp + 2'd1;
            end
            if (rd) begin
                rp <= rp + 2'd1;
                word_cnt <= word_cnt + 16'd1;
            end
            occ <= occ + 3'(wr_ok) - 3'(rd);
            if ((wr && occ == 3'd4) || (pop && empty_fifo)) error <= 1'b1;
        end
    end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter: data_width, default 10, width of FIFO data words.
REQ-002 Parameter: RD_LAT, default 2, cycles from pop sampled high to FIFO_data_out valid.
REQ-003 Parameter: BUF_DEPTH, default 4, output skid-buffer entries, fixed at 4.
REQ-004 Port: clk, input, 1, single clock; all logic on its rising edge.
REQ-005 Port: reset, input, 1, synchronous, active-low; 0 = reset, 1 = run.
REQ-006 Port: empty_fifo, input, 1, registered empty flag from the FIFO.
REQ-007 Port: almost_empty_fifo, input, 1, registered almost-empty flag from the FIFO.
REQ-008 Port: FIFO_data_out, input, data_width, FIFO read data.
REQ-009 Port: pop, output, 1, read request to the FIFO, registered.
REQ-010 Port: data_out, output, data_width, head word of the skid buffer.
REQ-011 Port: valid_out, output, 1, data_out holds a word.
REQ-012 Port: ready_in, input, 1, downstream accepts data_out when valid_out && ready_in.
REQ-013 Port: word_cnt, output, 16, count of words delivered downstream.
REQ-014 Port: error, output, 1, sticky flag: buffer overflow or pop issued while empty_fifo = 1.

Function
REQ-015 FSM states: IDLE, BURST, SINGLE, WAIT.
- IDLE: pop = 0.
- IDLE -> BURST when empty_fifo = 0, almost_empty_fifo = 0 and credit > 0.
- IDLE -> SINGLE when empty_fifo = 0, almost_empty_fifo = 1 and credit > 0.
REQ-016 BURST: pop = 1 every cycle while credit > 0 and almost_empty_fifo = 0; pop = 0 in any cycle with credit = 0; on almost_empty_fifo = 1 or empty_fifo = 1, go to WAIT.
REQ-017 SINGLE: issue exactly one pop cycle, then go to WAIT.
REQ-018 WAIT: pop = 0 for exactly RD_LAT cycles (flag settling), then go to IDLE.
REQ-019 Credit: credit = BUF_DEPTH - occupancy - inflight, where inflight = number of pops issued in the last RD_LAT cycles; pop is never asserted when credit = 0.
REQ-020 Inflight tracking: RD_LAT-deep shift register of issued pops; when a 1 leaves the last stage, write FIFO_data_out into the skid buffer in that same cycle.
REQ-021 Skid buffer:
- 4-entry circular buffer, 2-bit read and write pointers wrapping 3 -> 0, 3-bit occupancy 0..4.
- A simultaneous write and read leaves occupancy unchanged.
REQ-022 valid_out = (occupancy != 0); data_out = entry at the read pointer.
REQ-023 Downstream handshake:
- A word is consumed only on valid_out && ready_in.
- data_out and valid_out stay stable while ready_in = 0.
REQ-024 word_cnt increments by 1 per consumed word and wraps from 16'hFFFF to 0.
REQ-025 error sets on either condition and holds until reset:
- a write arrives while occupancy = 4;
- pop = 1 while empty_fifo = 1.

Reset
REQ-026 While reset = 0 at a rising edge, all of the following are cleared:
- pop = 0, state = IDLE;
- pointers, occupancy and inflight = 0;
- valid_out = 0, data_out = 0, word_cnt = 0, error = 0.
REQ-027 Reset mid-operation discards buffered and in-flight words; data returned after reset is ignored and not stored.
REQ-028 First pop is possible on the first edge after reset returns to 1.

Verification
REQ-029 FIFO holds 6 words 1..6, ready_in = 1:
- pops in consecutive cycles;
- data_out delivers 1..6 in order, first valid_out RD_LAT+1 cycles after first pop;
- word_cnt = 6, error = 0.
REQ-030 ready_in = 0, FIFO holds 8 words:
- exactly 4 pops issued, then pop = 0;
- valid_out = 1 with data_out = first word, stable;
- after ready_in = 1 the remaining 4 are fetched, no error.
REQ-031 almost_empty_fifo = 1 with 1 word:
- one pop, then 2 cycles with pop = 0 (WAIT), then IDLE;
- empty_fifo = 1 afterwards -> no further pops.
REQ-032 Reset to 0 while 2 words in flight and 3 buffered:
- next cycle valid_out = 0, word_cnt = 0, occupancy = 0;
- returned data ignored.
REQ-033 Force a write at occupancy = 4 by overriding credit -> error = 1, stays 1 until reset.
REQ-034 Deliver 65537 words -> word_cnt = 1 (wrap).
